// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: opcodes, sequencer states,
// control-word bit positions and the per-state control-word decode.
package cpu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
    localparam opcode_t OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_SHR  = 5'd5;
    localparam opcode_t OP_SHL  = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8;
    localparam opcode_t OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
    localparam opcode_t OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14;
    localparam opcode_t OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17;
    localparam opcode_t OP_BRX  = 5'd18, OP_JR   = 5'd19, OP_JAL  = 5'd20;
    localparam opcode_t OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
    localparam opcode_t OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

    typedef enum logic [3:0] {
        RESET, FETCH0, FETCH1, FETCH2, T3, T4, T5, T6, T7, MULDIV_WAIT, HALT
    } state_t;

    localparam int CW_PCOUT = 0,  CW_MDROUT = 1,  CW_ZHIOUT = 2,  CW_ZLOOUT = 3;
    localparam int CW_HIOUT = 4,  CW_LOOUT  = 5,  CW_INPORT = 6,  CW_COUT   = 7;
    localparam int CW_BAOUT = 8,  CW_PCIN   = 9,  CW_IRIN   = 10, CW_MARIN  = 11;
    localparam int CW_YIN   = 12, CW_ZIN    = 13, CW_MDRIN  = 14, CW_HIIN   = 15;
    localparam int CW_LOIN  = 16, CW_RIN    = 17, CW_ROUT   = 18, CW_GRA    = 19;
    localparam int CW_GRB   = 20, CW_GRC    = 21, CW_CONIN  = 22, CW_OUTPORT = 23;
    localparam int CW_READ  = 24, CW_WRITE  = 25, CW_AND    = 26, CW_OR     = 27;
    localparam int CW_ADD   = 28, CW_SUB    = 29, CW_MUL    = 30, CW_DIV    = 31;
    localparam int CW_SHR   = 32, CW_SHL    = 33, CW_ROR    = 34, CW_ROL    = 35;
    localparam int CW_NEG   = 36, CW_NOT    = 37, CW_INCPC  = 38, CW_DPCLR  = 39;
    localparam int CW_RUN   = 40, CW_W      = 41;

    typedef logic [CW_W-1:0] cword_t;

    function automatic cword_t alu_mask(opcode_t op);
        cword_t m;
        m = '0;
        case (op)
            OP_ADD, OP_ADDI: m[CW_ADD] = 1'b1;
            OP_AND, OP_ANDI: m[CW_AND] = 1'b1;
            OP_OR,  OP_ORI:  m[CW_OR]  = 1'b1;
            OP_SUB: m[CW_SUB] = 1'b1;
            OP_SHR: m[CW_SHR] = 1'b1;
            OP_SHL: m[CW_SHL] = 1'b1;
            OP_ROR: m[CW_ROR] = 1'b1;
            OP_ROL: m[CW_ROL] = 1'b1;
            OP_MUL: m[CW_MUL] = 1'b1;
            OP_DIV: m[CW_DIV] = 1'b1;
            OP_NEG: m[CW_NEG] = 1'b1;
            OP_NOT: m[CW_NOT] = 1'b1;
            default: ;
        endcase
        return m;
    endfunction

    // FETCH2 marks instructions with no execute step (nop, halt, undefined).
    function automatic state_t last_step(opcode_t op);
        case (op)
            OP_LD, OP_ST:                        return T7;
            OP_MUL, OP_DIV, OP_BRX:              return T6;
            OP_LDI, OP_ADDI, OP_ANDI, OP_ORI,
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:       return T5;
            OP_NEG, OP_NOT, OP_JAL:              return T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI,
            OP_MFLO:                             return T3;
            OP_NOP, OP_HALT:                     return FETCH2;
            default:                             return FETCH2;
        endcase
    endfunction

    function automatic cword_t decode(state_t s, opcode_t op, logic con_ff);
        cword_t c;
        c = '0;
        c[CW_RUN] = (s != RESET) && (s != HALT);
        case (s)
            RESET:  c[CW_DPCLR] = 1'b1;
            FETCH0: begin c[CW_PCOUT] = 1'b1; c[CW_MARIN] = 1'b1; c[CW_INCPC] = 1'b1; c[CW_ZIN] = 1'b1; end
            FETCH1: begin c[CW_ZLOOUT] = 1'b1; c[CW_PCIN] = 1'b1; c[CW_READ] = 1'b1; c[CW_MDRIN] = 1'b1; end
            FETCH2: begin c[CW_MDROUT] = 1'b1; c[CW_IRIN] = 1'b1; end
            T3: case (op)
                OP_LD, OP_LDI, OP_ST: begin c[CW_GRB] = 1'b1; c[CW_BAOUT] = 1'b1; c[CW_YIN] = 1'b1; end
                OP_MUL, OP_DIV:       begin c[CW_GRA] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_YIN] = 1'b1; end
                OP_NEG, OP_NOT:       begin c[CW_GRB] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_ZIN] = 1'b1; c |= alu_mask(op); end
                OP_BRX:  begin c[CW_GRA] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_CONIN] = 1'b1; end
                OP_JR:   begin c[CW_GRA] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_PCIN] = 1'b1; end
                OP_JAL:  begin c[CW_PCOUT] = 1'b1; c[CW_GRB] = 1'b1; c[CW_RIN] = 1'b1; end
                OP_IN:   begin c[CW_INPORT] = 1'b1; c[CW_GRA] = 1'b1; c[CW_RIN] = 1'b1; end
                OP_OUT:  begin c[CW_GRA] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_OUTPORT] = 1'b1; end
                OP_MFHI: begin c[CW_HIOUT] = 1'b1; c[CW_GRA] = 1'b1; c[CW_RIN] = 1'b1; end
                OP_MFLO: begin c[CW_LOOUT] = 1'b1; c[CW_GRA] = 1'b1; c[CW_RIN] = 1'b1; end
                OP_NOP, OP_HALT: ;
                default: if (op <= OP_ORI) begin c[CW_GRB] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_YIN] = 1'b1; end
            endcase
            T4: case (op)
                OP_LD, OP_LDI, OP_ST: begin c[CW_COUT] = 1'b1; c[CW_ADD] = 1'b1; c[CW_ZIN] = 1'b1; end
                OP_ADDI, OP_ANDI, OP_ORI: begin c[CW_COUT] = 1'b1; c[CW_ZIN] = 1'b1; c |= alu_mask(op); end
                OP_MUL, OP_DIV: begin c[CW_GRB] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_ZIN] = 1'b1; c |= alu_mask(op); end
                OP_NEG, OP_NOT: begin c[CW_ZLOOUT] = 1'b1; c[CW_GRA] = 1'b1; c[CW_RIN] = 1'b1; end
                OP_BRX: begin c[CW_PCOUT] = 1'b1; c[CW_YIN] = 1'b1; end
                OP_JAL: begin c[CW_GRA] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_PCIN] = 1'b1; end
                default: if (op >= OP_ADD && op <= OP_OR) begin
                    c[CW_GRC] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_ZIN] = 1'b1; c |= alu_mask(op);
                end
            endcase
            MULDIV_WAIT: begin c[CW_GRB] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_ZIN] = 1'b1; c |= alu_mask(op); end
            T5: case (op)
                OP_LD, OP_ST:   begin c[CW_ZLOOUT] = 1'b1; c[CW_MARIN] = 1'b1; end
                OP_MUL, OP_DIV: begin c[CW_ZLOOUT] = 1'b1; c[CW_LOIN] = 1'b1; end
                OP_BRX:         begin c[CW_COUT] = 1'b1; c[CW_ADD] = 1'b1; c[CW_ZIN] = 1'b1; end
                default:        begin c[CW_ZLOOUT] = 1'b1; c[CW_GRA] = 1'b1; c[CW_RIN] = 1'b1; end
            endcase
            T6: case (op)
                OP_LD:          begin c[CW_READ] = 1'b1; c[CW_MDRIN] = 1'b1; end
                OP_ST:          begin c[CW_GRA] = 1'b1; c[CW_ROUT] = 1'b1; c[CW_MDRIN] = 1'b1; end
                OP_MUL, OP_DIV: begin c[CW_ZHIOUT] = 1'b1; c[CW_HIIN] = 1'b1; end
                default: if (con_ff) begin c[CW_ZLOOUT] = 1'b1; c[CW_PCIN] = 1'b1; end
            endcase
            T7: if (op == OP_ST) c[CW_WRITE] = 1'b1;
                else begin c[CW_MDROUT] = 1'b1; c[CW_GRA] = 1'b1; c[CW_RIN] = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/flag/stop in, every control strobe out.
interface control_unit_if;
    logic [31:0] IR;
    logic CON_FF, stop;
    logic run, dp_clear;
    logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout;
    logic PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, Rout, Gra, Grb, Grc, CONin, OutPort;
    logic read, write;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;

    modport master (
        input  IR, CON_FF, stop,
        output run, dp_clear,
        output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
        output PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, Rout, Gra, Grb, Grc, CONin, OutPort,
        output read, write,
        output AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC
    );

    modport slave (
        output IR, CON_FF, stop,
        input  run, dp_clear,
        input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
        input  PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, Rout, Gra, Grb, Grc, CONin, OutPort,
        input  read, write,
        input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC
    );
endinterface

// File: rtl/muldiv_wait_counter.sv
// Holds the multiply/divide operate step: loads MULDIV_CYCLES-1, done at zero.
module muldiv_wait_counter #(
    parameter int unsigned MULDIV_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);
    if (MULDIV_CYCLES > 1) begin : g_cnt
        localparam int unsigned CNTW = $clog2(MULDIV_CYCLES);
        logic [CNTW-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                  cnt <= '0;
            else if (load)               cnt <= CNTW'(MULDIV_CYCLES - 1);
            else if (en && cnt != '0)    cnt <= cnt - 1'b1;
        end
        assign done = (cnt == '0);
    end else begin : g_none
        logic unused;
        assign unused = &{1'b0, clk, rst_n, load, en};
        assign done = 1'b1;
    end
endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the CPU datapath: fetch, per-opcode execute, halt.
module control_unit #(
    parameter int unsigned MULDIV_CYCLES = 1,
    parameter int unsigned OPW           = 5
) (
    input  logic           clk,
    input  logic           clear,
    control_unit_if.master ctl
);
    import cpu_pkg::*;

    state_t  state, state_d;
    cword_t  ctrl;
    opcode_t op;
    logic    stop_pend, halt_req, md_done, is_muldiv;
    logic    unused_ir;

    assign op        = opcode_t'(ctl.IR[31 -: OPW]);
    assign unused_ir = ^ctl.IR[31-OPW:0];
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);

    muldiv_wait_counter #(.MULDIV_CYCLES(MULDIV_CYCLES)) u_mdw (
        .clk   (clk),
        .rst_n (clear),
        .load  (state == T3),
        .en    (state == T4 || state == MULDIV_WAIT),
        .done  (md_done)
    );

    // A stop pulse anywhere inside an instruction is remembered until the boundary.
    always_comb begin
        halt_req = ctl.stop | stop_pend;
        state_d  = state;
        case (state)
            RESET:       state_d = ctrl[CW_DPCLR] ? FETCH0 : RESET;
            HALT:        state_d = HALT;
            MULDIV_WAIT: state_d = md_done ? T5 : MULDIV_WAIT;
            default: begin
                if (state == last_step(op)) begin
                    state_d = (halt_req || op == OP_HALT) ? HALT : FETCH0;
                end else begin
                    case (state)
                        FETCH0:  state_d = FETCH1;
                        FETCH1:  state_d = FETCH2;
                        FETCH2:  state_d = T3;
                        T3:      state_d = T4;
                        T4:      state_d = (is_muldiv && !md_done) ? MULDIV_WAIT : T5;
                        T5:      state_d = T6;
                        T6:      state_d = T7;
                        default: state_d = FETCH0;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= RESET;
            ctrl      <= '0;
            stop_pend <= 1'b0;
        end else begin
            state <= state_d;
            ctrl  <= decode(state_d, op, ctl.CON_FF);
            if (ctl.stop) stop_pend <= 1'b1;
        end
    end

    assign {ctl.run, ctl.dp_clear, ctl.IncPC, ctl.NOT, ctl.NEG, ctl.ROL, ctl.ROR,
            ctl.SHL, ctl.SHR, ctl.DIV, ctl.MUL, ctl.SUB, ctl.ADD, ctl.OR, ctl.AND,
            ctl.write, ctl.read, ctl.OutPort, ctl.CONin, ctl.Grc, ctl.Grb, ctl.Gra,
            ctl.Rout, ctl.Rin, ctl.LOin, ctl.HIin, ctl.MDRin, ctl.Zin, ctl.Yin,
            ctl.MARin, ctl.IRin, ctl.PCin, ctl.BAout, ctl.Cout, ctl.Inportout,
            ctl.LOout, ctl.HIout, ctl.Zlowout, ctl.Zhighout, ctl.MDRout, ctl.PCout} = ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors against hand-written expectations.
module tb_control_unit;

    logic clk = 1'b0;
    logic clear = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    control_unit_if cif();

    control_unit #(.MULDIV_CYCLES(4), .OPW(5)) dut (
        .clk   (clk),
        .clear (clear),
        .ctl   (cif)
    );

    always #5 clk = ~clk;

    localparam logic [40:0] M_RUN    = 41'd1 << 40, M_DPCLR  = 41'd1 << 39;
    localparam logic [40:0] M_PCOUT  = 41'd1 << 38, M_MDROUT = 41'd1 << 37;
    localparam logic [40:0] M_ZHI    = 41'd1 << 36, M_ZLO    = 41'd1 << 35;
    localparam logic [40:0] M_COUT   = 41'd1 << 31, M_BAOUT  = 41'd1 << 30;
    localparam logic [40:0] M_PCIN   = 41'd1 << 29, M_IRIN   = 41'd1 << 28;
    localparam logic [40:0] M_MARIN  = 41'd1 << 27, M_YIN    = 41'd1 << 26;
    localparam logic [40:0] M_ZIN    = 41'd1 << 25, M_MDRIN  = 41'd1 << 24;
    localparam logic [40:0] M_HIIN   = 41'd1 << 23, M_LOIN   = 41'd1 << 22;
    localparam logic [40:0] M_RIN    = 41'd1 << 21, M_ROUT   = 41'd1 << 20;
    localparam logic [40:0] M_GRA    = 41'd1 << 19, M_GRB    = 41'd1 << 18;
    localparam logic [40:0] M_GRC    = 41'd1 << 17, M_CONIN  = 41'd1 << 16;
    localparam logic [40:0] M_READ   = 41'd1 << 14, M_WRITE  = 41'd1 << 13;
    localparam logic [40:0] M_ADD    = 41'd1 << 10, M_MUL    = 41'd1 << 8;
    localparam logic [40:0] M_INCPC  = 41'd1 << 0;

    localparam logic [40:0] E_F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [40:0] E_F1 = M_RUN | M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [40:0] E_F2 = M_RUN | M_MDROUT | M_IRIN;

    function automatic logic [40:0] obs();
        return {cif.run, cif.dp_clear, cif.PCout, cif.MDRout, cif.Zhighout, cif.Zlowout,
                cif.HIout, cif.LOout, cif.Inportout, cif.Cout, cif.BAout, cif.PCin, cif.IRin,
                cif.MARin, cif.Yin, cif.Zin, cif.MDRin, cif.HIin, cif.LOin, cif.Rin, cif.Rout,
                cif.Gra, cif.Grb, cif.Grc, cif.CONin, cif.OutPort, cif.read, cif.write,
                cif.AND, cif.OR, cif.ADD, cif.SUB, cif.MUL, cif.DIV, cif.SHR, cif.SHL,
                cif.ROR, cif.ROL, cif.NEG, cif.NOT, cif.IncPC};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        repeat (3) step();
        vectors++;
        if (obs() !== 41'd0) begin
            miscompares++; $display("FAIL reset_held: got %h want %h", obs(), 41'd0);
        end
        clear = 1'b1;
        step();
        vectors++;
        if (obs() !== M_DPCLR) begin
            miscompares++; $display("FAIL reset_dpclear: got %h want %h", obs(), M_DPCLR);
        end
        step();
        vectors++;
        if (obs() !== E_F0) begin
            miscompares++; $display("FAIL reset_fetch0: got %h want %h", obs(), E_F0);
        end
    endtask

    task automatic test_add();
        logic [40:0] want [7];
        want = '{E_F0, E_F1, E_F2,
                 M_RUN | M_GRB | M_ROUT | M_YIN,
                 M_RUN | M_GRC | M_ROUT | M_ADD | M_ZIN,
                 M_RUN | M_ZLO | M_GRA | M_RIN,
                 E_F0};
        cif.IR = {5'd3, 27'h12345};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL add step %0d: got %h want %h", i, obs(), want[i]);
            end
        end
    endtask

    task automatic test_st();
        logic [40:0] want [9];
        want = '{E_F0, E_F1, E_F2,
                 M_RUN | M_GRB | M_BAOUT | M_YIN,
                 M_RUN | M_COUT | M_ADD | M_ZIN,
                 M_RUN | M_ZLO | M_MARIN,
                 M_RUN | M_GRA | M_ROUT | M_MDRIN,
                 M_RUN | M_WRITE,
                 E_F0};
        cif.IR = {5'd2, 27'h0};
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL st step %0d: got %h want %h", i, obs(), want[i]);
            end
        end
    endtask

    task automatic test_brx(input logic con);
        logic [40:0] want [8];
        want = '{E_F0, E_F1, E_F2,
                 M_RUN | M_GRA | M_ROUT | M_CONIN,
                 M_RUN | M_PCOUT | M_YIN,
                 M_RUN | M_COUT | M_ADD | M_ZIN,
                 con ? (M_RUN | M_ZLO | M_PCIN) : M_RUN,
                 E_F0};
        cif.IR = {5'd18, 27'h7};
        cif.CON_FF = con;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL brx con=%0d step %0d: got %h want %h", con, i, obs(), want[i]);
            end
        end
        cif.CON_FF = 1'b0;
    endtask

    task automatic test_mul();
        logic [40:0] want [11];
        want = '{E_F0, E_F1, E_F2,
                 M_RUN | M_GRA | M_ROUT | M_YIN,
                 M_RUN | M_GRB | M_ROUT | M_MUL | M_ZIN,
                 M_RUN | M_GRB | M_ROUT | M_MUL | M_ZIN,
                 M_RUN | M_GRB | M_ROUT | M_MUL | M_ZIN,
                 M_RUN | M_GRB | M_ROUT | M_MUL | M_ZIN,
                 M_RUN | M_ZLO | M_LOIN,
                 M_RUN | M_ZHI | M_HIIN,
                 E_F0};
        cif.IR = {5'd14, 27'h0};
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL mul step %0d: got %h want %h", i, obs(), want[i]);
            end
        end
    endtask

    task automatic test_jal();
        logic [40:0] want [6];
        want = '{E_F0, E_F1, E_F2,
                 M_RUN | M_PCOUT | M_GRB | M_RIN,
                 M_RUN | M_GRA | M_ROUT | M_PCIN,
                 E_F0};
        cif.IR = {5'd20, 27'h0};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL jal step %0d: got %h want %h", i, obs(), want[i]);
            end
        end
    endtask

    task automatic test_nop(input logic [4:0] opc);
        logic [40:0] want [4];
        want = '{E_F0, E_F1, E_F2, E_F0};
        cif.IR = {opc, 27'h5a5a};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL nop op=%0d step %0d: got %h want %h", opc, i, obs(), want[i]);
            end
        end
    endtask

    task automatic test_stop_ld();
        logic [40:0] want [10];
        want = '{E_F0, E_F1, E_F2,
                 M_RUN | M_GRB | M_BAOUT | M_YIN,
                 M_RUN | M_COUT | M_ADD | M_ZIN,
                 M_RUN | M_ZLO | M_MARIN,
                 M_RUN | M_READ | M_MDRIN,
                 M_RUN | M_MDROUT | M_GRA | M_RIN,
                 41'd0, 41'd0};
        cif.IR = {5'd0, 27'h0};
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL stop_ld step %0d: got %h want %h", i, obs(), want[i]);
            end
            if (i == 3) cif.stop = 1'b1;
            if (i == 4) cif.stop = 1'b0;
        end
    endtask

    task automatic test_clear_mid();
        logic [40:0] want [6];
        clear = 1'b0;
        step();
        clear = 1'b1;
        step();
        vectors++;
        if (obs() !== M_DPCLR) begin
            miscompares++; $display("FAIL restart_dpclear: got %h want %h", obs(), M_DPCLR);
        end
        step();
        step();
        vectors++;
        if (obs() !== E_F1) begin
            miscompares++; $display("FAIL restart_fetch1: got %h want %h", obs(), E_F1);
        end
        #2 clear = 1'b0;
        #1;
        vectors++;
        if (obs() !== 41'd0) begin
            miscompares++; $display("FAIL clear_async: got %h want %h", obs(), 41'd0);
        end
        step();
        vectors++;
        if (obs() !== 41'd0) begin
            miscompares++; $display("FAIL clear_held: got %h want %h", obs(), 41'd0);
        end
        want = '{M_DPCLR, E_F0, E_F1, E_F2, 41'd0, 41'd0};
        cif.IR = {5'd26, 27'h0};
        clear = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (obs() !== want[i]) begin
                miscompares++; $display("FAIL halt_op step %0d: got %h want %h", i, obs(), want[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cif.IR     = 32'd0;
        cif.CON_FF = 1'b0;
        cif.stop   = 1'b0;
        test_reset();
        test_add();
        test_st();
        test_brx(1'b0);
        test_brx(1'b1);
        test_mul();
        test_jal();
        test_nop(5'd25);
        test_nop(5'd31);
        test_stop_ld();
        test_clear_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore-style sequencer that drives every control strobe consumed by the CPU datapath: register-file selects, bus-source strobes, register load enables, ALU operation selects, memory read/write and I/O port strobes.
- Watches IR (datapath output) and CON_FF; runs the three-step fetch, then a per-opcode execute sequence, then returns to fetch.
- Sits beside the datapath at CPU top level and is the only driver of its control inputs.

Parameters:
- MULDIV_CYCLES, 1: cycles the MUL/DIV select and Zin are held in the multiply/divide operate step (range 1..32).
- OPW, 5: opcode field width, IR[31:27].

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-low reset (asserted at 0).
- IR  input  32  instruction register contents.
- CON_FF  input  1  branch-condition flag.
- stop  input  1  level request to halt at the next instruction boundary.
- run  output  1  1 while executing, 0 in RESET/HALT.
- dp_clear  output  1  datapath clear, high for exactly one cycle after reset release.
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout  output  1 each  bus source strobes.
- PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, Rout, Gra, Grb, Grc, CONin, OutPort  output  1 each  load enables and register selects.
- read, write  output  1 each  memory strobes.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC  output  1 each  ALU op selects, at most one high.

Behaviour:
- All outputs are registered, decoded from next state, and change only on clk rising edge.
- clear=0 asynchronously forces state RESET and all outputs 0 (run=0, dp_clear=0), including mid-instruction.
- RESET, first clk after clear deasserts: dp_clear=1, all other strobes 0. Next state FETCH0.
- FETCH0: PCout, MARin, IncPC, Zin.
- FETCH1: Zlowout, PCin, read, MDRin.
- FETCH2: MDRout, IRin. Then go to T3 using IR[31:27].
- Opcode decode, values in decimal:
  - ld 0, ldi 1, st 2
  - add 3, sub 4, shr 5, shl 6, ror 7, rol 8, and 9, or 10
  - addi 11, andi 12, ori 13, mul 14, div 15, neg 16, not 17
  - brx 18, jr 19, jal 20, in 21, out 22, mfhi 23, mflo 24, nop 25, halt 26
- Undefined opcodes 27..31 behave as nop.
- Execute sequences (T3 onward), one step per cycle:
  - R-type ALU: Grb,Rout,Yin | Grc,Rout,op,Zin | Zlowout,Gra,Rin.
  - Immediate ALU: Grb,Rout,Yin | Cout,op,Zin | Zlowout,Gra,Rin. addi uses ADD, andi uses AND, ori uses OR.
  - ld: Grb,BAout,Yin | Cout,ADD,Zin | Zlowout,MARin | read,MDRin | MDRout,Gra,Rin.
  - ldi: first three steps as ld, with Gra,Rin in place of MARin on the third.
  - st: Grb,BAout,Yin | Cout,ADD,Zin | Zlowout,MARin | Gra,Rout,MDRin | write.
  - mul/div: Gra,Rout,Yin | Grb,Rout,op,Zin (held MULDIV_CYCLES cycles) | Zlowout,LOin | Zhighout,HIin.
  - neg/not: Grb,Rout,op,Zin | Zlowout,Gra,Rin.
  - brx: Gra,Rout,CONin | PCout,Yin | Cout,ADD,Zin | Zlowout,PCin only if CON_FF=1, else an idle cycle.
  - jr: Gra,Rout,PCin.
  - jal: PCout,Grb,Rin (link register taken from the Rb field) | Gra,Rout,PCin.
  - in: Inportout,Gra,Rin. out: Gra,Rout,OutPort.
  - mfhi: HIout,Gra,Rin. mflo: LOout,Gra,Rin.
  - nop: no execute step; go straight to FETCH0.
- Instruction boundary = the cycle after an instruction's last step.
  - If stop=1 or the opcode is halt: enter HALT. Otherwise enter FETCH0.
  - HALT: run=0, all strobes 0; only clear exits it.
- run=1 in every state except RESET and HALT.
- Invariants:
  - Exactly one bus-source strobe high per cycle, or none.
  - read and write are never both high.
  - Rin and Rout are never both high.

Decomposition:
- Package cpu_pkg:
  - opcode localparams (OP_LD .. OP_HALT);
  - state enum (RESET, FETCH0..2, EXEC T3..T7, MULDIV_WAIT, HALT);
  - control-word bit indices.
- Sub-module muldiv_wait_counter: loads MULDIV_CYCLES-1 and signals done at zero. Omitted logic when MULDIV_CYCLES=1.

Test Plan:
- clear low 3 cycles, then high: dp_clear=1 for one cycle, then FETCH0 with PCout=MARin=IncPC=Zin=1; run=1.
- IR opcode add (0x18000000-class): 6 cycles from FETCH0 to the next FETCH0. T4 has Grc,Rout,ADD,Zin. T5 has Zlowout,Gra,Rin.
- st: T6 has Gra,Rout,MDRin and T7 has write=1, with read=0 throughout execute.
- brx with CON_FF=0: no PCin in T6. Repeat with CON_FF=1: T6 has Zlowout,PCin.
- mul with MULDIV_CYCLES=4: MUL=Zin=1 for exactly 4 consecutive cycles, followed by LOin, then HIin.
- Pulse stop during an ld: the ld completes all 8 steps, then HALT with run=0. Asserting clear=0 mid-FETCH1 drops all outputs to 0 immediately.
